// File: rtl/gfb_pkg.sv
// gfb_pkg -- shared definitions for the gfb command queue.
//   * Command encodings on the CMD bus (IDLE..MASS_ERASE).
//   * Handshake FSM state type.
//   * Default address / write-data widths.
//   * Helpers that classify a raw 3-bit CMD value.
package gfb_pkg;

  localparam int GFB_AW = 10;
  localparam int GFB_DW = 10;

  typedef enum logic [2:0] {
    CMD_IDLE       = 3'd0,
    CMD_READ       = 3'd1,
    CMD_WRITE      = 3'd2,
    CMD_ROW_WRITE  = 3'd3,
    CMD_ERASE      = 3'd4,
    CMD_MASS_ERASE = 3'd5
  } gfb_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } gfb_state_e;

  // A real command that should be queued.
  function automatic logic gfb_cmd_valid(input logic [2:0] c);
    return (c >= CMD_READ) && (c <= CMD_MASS_ERASE);
  endfunction

  // Encodings 6 and 7 have no meaning and are flagged as errors.
  function automatic logic gfb_cmd_illegal(input logic [2:0] c);
    return c[2] & c[1];
  endfunction

endpackage

// File: rtl/gfb_sync.sv
// gfb_sync -- multi-flop bit synchronizer.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, clears every stage
//   i_d      asynchronous input bit
//   o_q      synchronized output (last stage of the chain)
module gfb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gfb_cmd_queue.sv
// gfb_cmd_queue -- command FIFO feeding a four-phase req/ack handshake
// toward a slave running on an unrelated clock.
// Ports:
//   PCLK, RESETn_pclk      clock, asynchronous active-low reset
//   CMD, ADDR, WDATA       command push bus (CMD=0 means no push)
//   ABORT                  level-sampled flush of queued entries
//   READY_pclk             registered "queue not full"
//   RESP_pclk              one-cycle pulse per completed handshake
//   ERR_pclk               sticky error (illegal cmd, overflow, timeout)
//   LEVEL_pclk             queued entries, not counting the in-flight one
//   CMD/ADDR/WDATA_REG_pclk  in-flight command presented to the slave
//   ABORT_REG_pclk         tells the slave a flush happened mid-handshake
//   req_pclk / ack_sclk    four-phase handshake pair
module gfb_cmd_queue
  import gfb_pkg::*;
#(
  parameter int AW          = GFB_AW,
  parameter int DW          = GFB_DW,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     PCLK,
  input  logic                     RESETn_pclk,
  input  logic [2:0]               CMD,
  input  logic [AW-1:0]            ADDR,
  input  logic [DW-1:0]            WDATA,
  input  logic                     ABORT,
  output logic                     READY_pclk,
  output logic                     RESP_pclk,
  output logic                     ERR_pclk,
  output logic [$clog2(DEPTH):0]   LEVEL_pclk,
  output logic [2:0]               CMD_REG_pclk,
  output logic [AW-1:0]            ADDR_REG_pclk,
  output logic [DW-1:0]            WDATA_REG_pclk,
  output logic                     ABORT_REG_pclk,
  output logic                     req_pclk,
  input  logic                     ack_sclk
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int EW = 3 + AW + DW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  // Queue storage is deliberately left without reset.
  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic            r_ready;
  logic            r_err;

  gfb_state_e      r_state;
  logic            r_req;
  logic            r_resp;
  logic            r_abort_reg;
  logic [2:0]      r_cmd;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [TW-1:0]   r_tcnt;

  logic            w_ack_s;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_illegal;
  logic            w_overflow;
  logic            w_timeout;
  logic            w_done;
  logic [PW-1:0]   w_wptr_nxt;
  logic [PW-1:0]   w_rptr_nxt;
  logic            w_full_nxt;
  logic [EW-1:0]   w_head;

  gfb_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk   (PCLK),
    .i_rst_n (RESETn_pclk),
    .i_d     (ack_sclk),
    .o_q     (w_ack_s)
  );

  assign w_empty    = (r_wptr == r_rptr);
  assign w_illegal  = gfb_cmd_illegal(CMD);
  // ABORT discards a simultaneous push without flagging it as an overflow.
  assign w_push     = gfb_cmd_valid(CMD) && r_ready && !ABORT;
  assign w_overflow = gfb_cmd_valid(CMD) && !r_ready && !ABORT;
  // The FSM only sits in IDLE for a cycle after REL, so a pop can never
  // happen on the edge IDLE is entered.
  assign w_pop      = (r_state == ST_IDLE) && !w_empty && !ABORT;
  assign w_done     = (r_state == ST_REL) && !w_ack_s;

  assign w_wptr_nxt = r_wptr + PW'(w_push);
  // A flush just moves the read pointer onto the write pointer.
  assign w_rptr_nxt = ABORT ? r_wptr : (r_rptr + PW'(w_pop));
  assign w_full_nxt = (w_wptr_nxt[PW-1] != w_rptr_nxt[PW-1]) &&
                      (w_wptr_nxt[PW-2:0] == w_rptr_nxt[PW-2:0]);
  assign w_head     = r_mem[r_rptr[PW-2:0]];

  // The counter is loaded with 1 on the pop edge so it equals the number of
  // REQ cycles seen; the error rises together with the count hitting TIMEOUT.
  assign w_timeout  = ((r_state == ST_REQ) && !w_ack_s && (r_tcnt != TMAX) &&
                       ((r_tcnt + TW'(1)) == TMAX)) ||
                      (w_pop && (TMAX == TW'(1)));

  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem[r_wptr[PW-2:0]] <= {CMD, ADDR, WDATA};
    end
  end

  // READY is registered from next-state pointers so it never lets a push
  // land on a full queue; a push on the edge a pop frees a slot still sees
  // the old READY=0 and is rejected.
  always_ff @(posedge PCLK or negedge RESETn_pclk) begin
    if (!RESETn_pclk) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_ready <= !w_full_nxt;
      if (w_illegal || w_overflow || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge RESETn_pclk) begin
    if (!RESETn_pclk) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_resp      <= 1'b0;
      r_abort_reg <= 1'b0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tcnt      <= '0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_cmd, r_addr, r_wdata} <= w_head;
            r_req   <= 1'b1;
            r_tcnt  <= TW'(1);
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A timeout only raises ERR; req stays up until the slave answers.
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_state <= ST_REL;
          end else if (r_tcnt != TMAX) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        ST_REL: begin
          if (!w_ack_s) begin
            r_resp  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Completion clears the marker even if ABORT arrives on that same edge.
      if (w_done) begin
        r_abort_reg <= 1'b0;
      end else if (ABORT && (r_state != ST_IDLE)) begin
        r_abort_reg <= 1'b1;
      end
    end
  end

  assign READY_pclk     = r_ready;
  assign RESP_pclk      = r_resp;
  assign ERR_pclk       = r_err;
  assign LEVEL_pclk     = r_wptr - r_rptr;
  assign CMD_REG_pclk   = r_cmd;
  assign ADDR_REG_pclk  = r_addr;
  assign WDATA_REG_pclk = r_wdata;
  assign ABORT_REG_pclk = r_abort_reg;
  assign req_pclk       = r_req;

endmodule

// File: tb/tb_gfb_cmd_queue.sv
// Testbench for gfb_cmd_queue: a queue-based reference model, a slave
// responder with configurable ack delay, and a monitor that checks every
// issued command against the model.
module tb_gfb_cmd_queue;

  localparam int AW    = 10;
  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          RESETn_pclk = 1'b1;
  logic [2:0]    CMD = '0;
  logic [AW-1:0] ADDR = '0;
  logic [DW-1:0] WDATA = '0;
  logic          ABORT = 1'b0;
  logic          ack_sclk = 1'b0;
  logic          READY_pclk, RESP_pclk, ERR_pclk, ABORT_REG_pclk, req_pclk;
  logic [LW-1:0] LEVEL_pclk;
  logic [2:0]    CMD_REG_pclk;
  logic [AW-1:0] ADDR_REG_pclk;
  logic [DW-1:0] WDATA_REG_pclk;

  typedef struct packed {
    logic [2:0]    c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  ent_t cur;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_resp = 0;
  bit   mon_active = 0;
  bit   prev_req = 0;
  bit   exp_abort = 0;
  bit   exp_err = 0;
  bit   ack_en = 0;
  bit   rand_dly = 0;
  int   s_st = 0;
  int   s_cnt = 0;

  gfb_cmd_queue #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT(8)
  ) dut (
    .PCLK           (PCLK),
    .RESETn_pclk    (RESETn_pclk),
    .CMD            (CMD),
    .ADDR           (ADDR),
    .WDATA          (WDATA),
    .ABORT          (ABORT),
    .READY_pclk     (READY_pclk),
    .RESP_pclk      (RESP_pclk),
    .ERR_pclk       (ERR_pclk),
    .LEVEL_pclk     (LEVEL_pclk),
    .CMD_REG_pclk   (CMD_REG_pclk),
    .ADDR_REG_pclk  (ADDR_REG_pclk),
    .WDATA_REG_pclk (WDATA_REG_pclk),
    .ABORT_REG_pclk (ABORT_REG_pclk),
    .req_pclk       (req_pclk),
    .ack_sclk       (ack_sclk)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // One bus cycle: drive inputs just after the falling edge and update the
  // model with what the queue should do at the next rising edge.
  task automatic step(input logic [2:0] c, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic ab);
    ent_t e;
    @(negedge PCLK); #1;
    CMD = c; ADDR = a; WDATA = d; ABORT = ab;
    if (ab) begin
      exp_q.delete();
      if (mon_active) exp_abort = 1;
    end else if (c == 3'd6 || c == 3'd7) begin
      exp_err = 1;
    end else if (c != 3'd0) begin
      if (exp_q.size() < DEPTH) begin
        e.c = c; e.a = a; e.d = d;
        exp_q.push_back(e);
      end else begin
        exp_err = 1;
      end
    end
  endtask

  task automatic idle();
    step(3'd0, '0, '0, 1'b0);
  endtask

  task automatic push_rand();
    step(3'($urandom_range(1, 5)), AW'($urandom), DW'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge PCLK); #1;
    RESETn_pclk = 0; CMD = '0; ABORT = 0;
    exp_q.delete(); exp_abort = 0; exp_err = 0;
    repeat (2) @(negedge PCLK);
    #1 RESETn_pclk = 1;
  endtask

  task automatic wait_resp(input int target, input int budget, input string tag);
    int k = 0;
    while (n_resp < target && k < budget) begin
      idle();
      k++;
    end
    chk(tag, 32'(n_resp >= target), 32'd1);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int k = 0;
    while (!req_pclk && k < budget) begin
      idle();
      k++;
    end
    chk(tag, 32'(req_pclk), 32'd1);
  endtask

  function automatic int ack_delay();
    return rand_dly ? int'($urandom_range(2, 6)) : 3;
  endfunction

  // Slave: raise ack a few cycles after req rises, drop it a few cycles
  // after req falls.
  initial begin
    forever begin
      @(negedge PCLK);
      if (!RESETn_pclk || !ack_en) begin
        ack_sclk = 0;
        s_st = 0;
      end else begin
        case (s_st)
          0: if (req_pclk) begin s_cnt = ack_delay(); s_st = 1; end
          1: begin s_cnt--; if (s_cnt == 0) begin ack_sclk = 1; s_st = 2; end end
          2: if (!req_pclk) begin s_cnt = ack_delay(); s_st = 3; end
          default: begin s_cnt--; if (s_cnt == 0) begin ack_sclk = 0; s_st = 0; end end
        endcase
      end
    end
  end

  // Monitor: issue order, register stability, level/ready/abort marker.
  initial begin
    forever begin
      @(negedge PCLK);
      if (!RESETn_pclk) begin
        mon_active = 0; prev_req = 0; exp_abort = 0;
      end else begin
        if (req_pclk && !prev_req) begin
          chk("req_has_entry", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("issue_cmd", 32'(CMD_REG_pclk), 32'(cur.c));
            chk("issue_addr", 32'(ADDR_REG_pclk), 32'(cur.a));
            chk("issue_wdata", 32'(WDATA_REG_pclk), 32'(cur.d));
          end
          mon_active = 1;
        end
        if (RESP_pclk) begin
          chk("resp_in_handshake", {30'd0, mon_active, req_pclk}, 32'd2);
          n_resp++;
          mon_active = 0;
          exp_abort = 0;
        end
        if (mon_active) begin
          chk("hold_cmd", 32'(CMD_REG_pclk), 32'(cur.c));
          chk("hold_addr", 32'(ADDR_REG_pclk), 32'(cur.a));
          chk("hold_wdata", 32'(WDATA_REG_pclk), 32'(cur.d));
        end
        chk("level", 32'(LEVEL_pclk), 32'(exp_q.size()));
        chk("ready", 32'(READY_pclk), 32'(exp_q.size() < DEPTH));
        chk("abort_reg", 32'(ABORT_REG_pclk), 32'(exp_abort));
        prev_req = req_pclk;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    ent_t items[11];
    int idx;
    int k;

    // Reset state
    #1 RESETn_pclk = 0;
    #11;
    chk("rst_req", 32'(req_pclk), 0);
    chk("rst_resp", 32'(RESP_pclk), 0);
    chk("rst_err", 32'(ERR_pclk), 0);
    chk("rst_abort_reg", 32'(ABORT_REG_pclk), 0);
    chk("rst_cmd_reg", 32'(CMD_REG_pclk), 0);
    chk("rst_addr_reg", 32'(ADDR_REG_pclk), 0);
    chk("rst_wdata_reg", 32'(WDATA_REG_pclk), 0);
    chk("rst_level", 32'(LEVEL_pclk), 0);
    chk("rst_ready", 32'(READY_pclk), 0);
    @(negedge PCLK); #1 RESETn_pclk = 1;
    @(negedge PCLK); #1;
    chk("ready_after_rst", 32'(READY_pclk), 1);

    // Single write with 3-cycle ack delays
    ack_en = 1; rand_dly = 0; base = n_resp;
    step(3'd2, 10'h155, 10'h2AA, 1'b0);
    idle();
    chk("lat_req_low", 32'(req_pclk), 0);
    chk("lat_level", 32'(LEVEL_pclk), 1);
    idle();
    chk("lat_req_high", 32'(req_pclk), 1);
    chk("sw_cmd", 32'(CMD_REG_pclk), 32'd2);
    chk("sw_addr", 32'(ADDR_REG_pclk), 32'h155);
    chk("sw_wdata", 32'(WDATA_REG_pclk), 32'h2AA);
    wait_resp(base + 1, 60, "sw_resp_seen");
    repeat (10) idle();
    chk("sw_resp_count", 32'(n_resp - base), 32'd1);
    chk("sw_err", 32'(ERR_pclk), 0);

    // Timeout: ack never rises
    do_reset();
    ack_en = 0;
    push_rand();
    wait_req(10, "to_req_rise");
    for (int cyc = 1; cyc < 8; cyc++) begin
      chk("to_err_early", 32'(ERR_pclk), 0);
      idle();
    end
    chk("to_err_set", 32'(ERR_pclk), 1);
    chk("to_req_held", 32'(req_pclk), 1);
    repeat (5) idle();
    chk("to_req_still", 32'(req_pclk), 1);

    // Full: ack tied low, 6 pushes
    do_reset();
    ack_en = 0;
    repeat (6) push_rand();
    idle();
    chk("full_ready", 32'(READY_pclk), 0);
    chk("full_err", 32'(ERR_pclk), 32'(exp_err));
    chk("full_level", 32'(LEVEL_pclk), 32'd4);
    chk("full_req", 32'(req_pclk), 1);

    // Abort with one in flight and three queued, plus a push on the abort edge
    do_reset();
    ack_en = 0; rand_dly = 0;
    repeat (4) push_rand();
    idle();
    chk("ab_level_pre", 32'(LEVEL_pclk), 32'd3);
    base = n_resp;
    step(3'd1, AW'($urandom), DW'($urandom), 1'b1);
    idle();
    chk("ab_level", 32'(LEVEL_pclk), 0);
    chk("ab_marker", 32'(ABORT_REG_pclk), 1);
    chk("ab_req_kept", 32'(req_pclk), 1);
    ack_en = 1;
    wait_resp(base + 1, 60, "ab_resp_seen");
    idle();
    chk("ab_marker_clr", 32'(ABORT_REG_pclk), 0);
    repeat (20) idle();
    chk("ab_resp_count", 32'(n_resp - base), 32'd1);
    chk("ab_no_req", 32'(req_pclk), 0);
    step(3'd0, '0, '0, 1'b1);
    idle();
    chk("ab_idle_marker", 32'(ABORT_REG_pclk), 0);

    // Wrap: 10 commands, random ack delay, one illegal CMD=7
    do_reset();
    ack_en = 1; rand_dly = 1; base = n_resp;
    for (int i = 0; i < 11; i++) begin
      items[i].c = (i == 5) ? 3'd7 : 3'($urandom_range(1, 5));
      items[i].a = AW'($urandom);
      items[i].d = DW'($urandom);
    end
    idx = 0; k = 0;
    while (idx < 11 && k < 600) begin
      if (items[idx].c == 3'd7 || exp_q.size() < DEPTH) begin
        step(items[idx].c, items[idx].a, items[idx].d, 1'b0);
        idx++;
      end else begin
        idle();
      end
      k++;
    end
    chk("wrap_all_pushed", 32'(idx), 32'd11);
    wait_resp(base + 10, 1500, "wrap_resp_seen");
    repeat (10) idle();
    chk("wrap_resp_count", 32'(n_resp - base), 32'd10);
    chk("wrap_err", 32'(ERR_pclk), 32'(exp_err));
    chk("wrap_level", 32'(LEVEL_pclk), 0);

    // Reset in the middle of a handshake
    do_reset();
    ack_en = 0; rand_dly = 0;
    push_rand();
    push_rand();
    wait_req(10, "mid_req_rise");
    #2 RESETn_pclk = 0;
    exp_q.delete(); exp_abort = 0; exp_err = 0;
    #1;
    chk("mid_req_drop", 32'(req_pclk), 0);
    chk("mid_level", 32'(LEVEL_pclk), 0);
    chk("mid_ready", 32'(READY_pclk), 0);
    chk("mid_resp", 32'(RESP_pclk), 0);
    repeat (2) @(negedge PCLK);
    #1 RESETn_pclk = 1;
    ack_en = 1; base = n_resp;
    push_rand();
    wait_resp(base + 1, 60, "mid_fresh_resp");
    repeat (10) idle();
    chk("mid_resp_count", 32'(n_resp - base), 32'd1);
    chk("mid_err", 32'(ERR_pclk), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gfb_cmd_queue.md
GFB_CMD_QUEUE -- requirements
Module: gfb_cmd_queue

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  AW  10  address width.
  DW  10  write-data width.
  DEPTH  4  command queue entries, power of two, >= 2.
  SYNC_STAGES  2  flops in the ack synchronizer, >= 2.
  TIMEOUT  255  maximum cycles from req_pclk rise to synced ack rise.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  PCLK  in  1  the single clock.
  RESETn_pclk  in  1  asynchronous active-low reset.
  CMD  in  3  command: IDLE=0, READ=1, WRITE=2, ROW_WRITE=3, ERASE=4, MASS_ERASE=5.
  ADDR  in  AW  command address.
  WDATA  in  DW  command write data.
  ABORT  in  1  flush request, level-sampled.
  READY_pclk  out  1  queue not full.
  RESP_pclk  out  1  one-cycle pulse on each completed handshake.
  ERR_pclk  out  1  sticky error flag.
  LEVEL_pclk  out  log2(DEPTH)+1  queued entry count, excluding the in-flight entry.
  CMD_REG_pclk  out  3  in-flight command.
  ADDR_REG_pclk  out  AW  in-flight address.
  WDATA_REG_pclk  out  DW  in-flight write data.
  ABORT_REG_pclk  out  1  abort marker toward the slave.
  req_pclk  out  1  four-phase request.
  ack_sclk  in  1  four-phase acknowledge, asynchronous to PCLK.
REQ-003 Clocking and reset SHALL be fixed: one clock, PCLK; reset RESETn_pclk is asynchronous and active-low.

Function
REQ-004 Push: a cycle with CMD in 1..5 and READY_pclk=1 SHALL enqueue {CMD, ADDR, WDATA}.
REQ-005 CMD=0 SHALL be ignored.
REQ-006 CMD=6 or 7 SHALL be dropped and SHALL set ERR_pclk.
REQ-007 Push while full (READY_pclk=0) SHALL be dropped and SHALL set ERR_pclk; READY_pclk SHALL be !full, registered.
REQ-008 ack_sclk SHALL pass through a SYNC_STAGES flop chain; only the synced value ack_s SHALL be used.
REQ-009 The FSM SHALL have three states:
  IDLE: on the edge when the queue is non-empty, pop the head, load the *_REG_pclk outputs, set req_pclk=1, go to REQ.
  REQ: on ack_s=1, clear req_pclk, go to REL.
  REL: on ack_s=0, pulse RESP_pclk for one cycle, go to IDLE.
REQ-010 The *_REG_pclk outputs SHALL hold stable from req_pclk rise until RESP_pclk.
REQ-011 Latency: a push at edge N into an empty queue with the FSM in IDLE SHALL give req_pclk=1 after edge N+1.
REQ-012 Back-to-back: IDLE SHALL NOT pop on the edge it is entered; each handshake has at least one IDLE cycle.
REQ-013 Push and pop on the same edge SHALL both take effect, and LEVEL_pclk SHALL stay unchanged.
REQ-014 A push on the edge the queue becomes non-full SHALL still be rejected, because READY_pclk lags by one cycle.
REQ-015 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-016 full SHALL be (MSBs differ and the other bits are equal); empty SHALL be (pointers equal).
REQ-017 ABORT=1 SHALL empty the queue in one cycle.
REQ-018 ABORT SHALL win over a simultaneous push; that push SHALL be discarded.
REQ-019 ABORT SHALL NOT cut short an in-flight handshake.
REQ-020 If the FSM is not in IDLE when ABORT is sampled, ABORT_REG_pclk SHALL be set and held until the next RESP_pclk, then cleared.
REQ-021 Timeout: a counter SHALL run while in REQ; reaching TIMEOUT SHALL set ERR_pclk.
REQ-022 On timeout, req_pclk SHALL stay high; the handshake is never abandoned.
REQ-023 ERR_pclk SHALL clear only on reset.

Reset
REQ-024 Reset SHALL give: FSM=IDLE, pointers=0, req_pclk=0, RESP_pclk=0, ERR_pclk=0, ABORT_REG_pclk=0, CMD_REG_pclk=0, ADDR_REG_pclk=0, WDATA_REG_pclk=0, LEVEL_pclk=0, synchronizer flops=0, timeout counter=0.
REQ-025 READY_pclk SHALL be 0 while RESETn_pclk is low and 1 from the first edge after release.
REQ-026 Reset mid-handshake SHALL drop req_pclk immediately and discard all queued and in-flight entries, with no RESP_pclk.
REQ-027 Queue storage SHALL NOT be reset.

Structure
REQ-028 A shared package gfb_pkg SHALL hold the CMD encodings (IDLE..MASS_ERASE), the FSM state type, and the default AW/DW.
REQ-029 One sub-module, gfb_sync (a SYNC_STAGES-parameterised bit synchronizer), SHALL be instantiated for ack_sclk; the FIFO SHALL be inline.

Verification
REQ-030 Single write: push CMD=2, ADDR=0x155, WDATA=0x2AA; ack_sclk rises 3 cycles after req_pclk and falls 3 cycles after req_pclk falls -> registers hold 2/0x155/0x2AA throughout, req_pclk=1 one cycle after the push, exactly one RESP_pclk pulse.
REQ-031 Full: push 5 commands with ack_sclk tied low -> READY_pclk=0 after 5 accepted (4 queued + 1 in flight), 6th push dropped, ERR_pclk=1, LEVEL_pclk=4.
REQ-032 Abort: 3 commands queued, one in flight; assert ABORT for one cycle -> LEVEL_pclk=0, ABORT_REG_pclk=1 until the in-flight RESP_pclk, no further req_pclk.
REQ-033 Timeout: TIMEOUT=8, ack_sclk never rises -> ERR_pclk=1 on the 8th REQ cycle, req_pclk stays 1.
REQ-034 Wrap and illegal: 10 sequential commands with a random ack delay of 2..6 cycles and one CMD=7 interleaved -> 10 RESP_pclk pulses, issued in push order, CMD=7 never issued, ERR_pclk=1.
REQ-035 Reset mid-operation: assert RESETn_pclk low while in REQ -> req_pclk=0 asynchronously and LEVEL_pclk=0; after release, a fresh push completes normally.
